// File: rtl/usadd_pkg.sv
// Shared constants and width helpers for the multi-input unipolar stochastic adder.
package usadd_pkg;

   localparam int MODE_SCALED    = 0;
   localparam int MODE_NONSCALED = 1;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Scaled mode holds acc + popcount, whose maximum is 2*num_in-1.
   function automatic int scaled_acc_w(input int num_in);
      return clog2(2 * num_in);
   endfunction

endpackage

// File: rtl/usadd_multi_parallelcnt_n.sv
// Combinational popcount of an NUM_IN-bit vector; generalises the two-input parallel counter.
module parallelcnt_n
   import usadd_pkg::*;
#(
   parameter int NUM_IN = 4,
   localparam int CNT_W = clog2(NUM_IN + 1)
) (
   input  logic [NUM_IN-1:0] i_bits,
   output logic [CNT_W-1:0]  o_count
);

   always_comb begin
      o_count = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         o_count = o_count + CNT_W'(i_bits[i]);
      end
   end

endmodule

// File: rtl/usadd_multi.sv
// N-input stochastic adder: popcount into a residue accumulator, one registered output bit per
// cycle, with a frame counter that discards the residue at every frame boundary.
module usadd_multi
   import usadd_pkg::*;
#(
   parameter int NUM_IN   = 4,
   parameter int BITWIDTH = 8,
   parameter int MODE     = 0,
   parameter int ACC_W    = 4
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iClr,
   input  logic              iEn,
   input  logic [NUM_IN-1:0] iA,
   output logic              oC,
   output logic              oDone
);

   localparam int CNT_W = clog2(NUM_IN + 1);

   logic [CNT_W-1:0]    w_sum;
   logic [BITWIDTH-1:0] r_cnt;
   logic                w_last;
   logic                w_c_next;
   logic                r_c;
   logic                r_done;

   parallelcnt_n #(.NUM_IN(NUM_IN)) u_popcnt (
      .i_bits  (iA),
      .o_count (w_sum)
   );

   assign w_last = (r_cnt == '1);

   generate
      if (MODE == MODE_SCALED) begin : g_scaled
         localparam int SW = scaled_acc_w(NUM_IN);
         logic [SW-1:0] r_acc;
         logic [SW-1:0] w_t;
         logic [SW-1:0] w_acc_next;

         always_comb begin
            w_t        = r_acc + SW'(w_sum);
            w_c_next   = 1'b0;
            w_acc_next = w_t;
            if (w_t >= SW'(NUM_IN)) begin
               w_c_next   = 1'b1;
               w_acc_next = w_t - SW'(NUM_IN);
            end
         end

         always_ff @(posedge iClk or posedge iRst) begin
            if (iRst) begin
               r_acc <= '0;
            end else if (iClr) begin
               r_acc <= '0;
            end else if (iEn) begin
               r_acc <= w_last ? '0 : w_acc_next;
            end
         end
      end else begin : g_nonscaled
         logic [ACC_W-1:0] r_acc;
         logic [ACC_W:0]   w_t;
         logic [ACC_W:0]   w_dec;
         logic [ACC_W-1:0] w_acc_next;

         // Backlog of ones still owed; anything beyond the register's range is dropped.
         always_comb begin
            w_t        = {1'b0, r_acc} + (ACC_W + 1)'(w_sum);
            w_dec      = w_t - 1'b1;
            w_c_next   = 1'b0;
            w_acc_next = '0;
            if (w_t != '0) begin
               w_c_next   = 1'b1;
               w_acc_next = w_dec[ACC_W] ? '1 : w_dec[ACC_W-1:0];
            end
         end

         always_ff @(posedge iClk or posedge iRst) begin
            if (iRst) begin
               r_acc <= '0;
            end else if (iClr) begin
               r_acc <= '0;
            end else if (iEn) begin
               r_acc <= w_last ? '0 : w_acc_next;
            end
         end
      end
   endgenerate

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_cnt  <= '0;
         r_c    <= 1'b0;
         r_done <= 1'b0;
      end else if (iClr) begin
         r_cnt  <= '0;
         r_c    <= 1'b0;
         r_done <= 1'b0;
      end else if (iEn) begin
         r_cnt  <= r_cnt + 1'b1;
         r_c    <= w_c_next;
         r_done <= w_last;
      end else begin
         r_c    <= 1'b0;
         r_done <= 1'b0;
      end
   end

   assign oC    = r_c;
   assign oDone = r_done;

endmodule

// File: tb/tb_usadd_multi.sv
// Bench for usadd_multi: four configurations side by side, a behavioural model feeding an
// expected-output queue, and directed plus random phases.
module tb_usadd_multi;

   logic       iClk;
   logic       iRst;
   logic       iClr;
   logic       iEn;
   logic [3:0] a_s4, a_n4, a_n3;
   logic [2:0] a_s3;
   logic       c_s4, d_s4, c_n4, d_n4, c_n3, d_n3, c_s3, d_s3;

   // Instance k: 0 scaled N4 BW8, 1 nonscaled N4 ACC4, 2 nonscaled N4 ACC3, 3 scaled N3 BW4.
   int m_n[4]    = '{4, 4, 4, 3};
   int m_bw[4]   = '{8, 8, 8, 4};
   int m_mode[4] = '{0, 1, 1, 0};
   int m_accw[4] = '{4, 4, 3, 4};
   int m_acc[4];
   int m_cnt[4];

   logic [7:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;
   string phase = "init";
   int ones[4];
   int dones[4];
   int done_pos[4];
   int out_idx;

   usadd_multi #(.NUM_IN(4), .BITWIDTH(8), .MODE(0), .ACC_W(4)) u_s4 (
      .iClk(iClk), .iRst(iRst), .iClr(iClr), .iEn(iEn), .iA(a_s4), .oC(c_s4), .oDone(d_s4));
   usadd_multi #(.NUM_IN(4), .BITWIDTH(8), .MODE(1), .ACC_W(4)) u_n4 (
      .iClk(iClk), .iRst(iRst), .iClr(iClr), .iEn(iEn), .iA(a_n4), .oC(c_n4), .oDone(d_n4));
   usadd_multi #(.NUM_IN(4), .BITWIDTH(8), .MODE(1), .ACC_W(3)) u_n3 (
      .iClk(iClk), .iRst(iRst), .iClr(iClr), .iEn(iEn), .iA(a_n3), .oC(c_n3), .oDone(d_n3));
   usadd_multi #(.NUM_IN(3), .BITWIDTH(4), .MODE(0), .ACC_W(4)) u_s3 (
      .iClk(iClk), .iRst(iRst), .iClr(iClr), .iEn(iEn), .iA(a_s3), .oC(c_s3), .oDone(d_s3));

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s/%s: got 'h%0h expected 'h%0h at %0t", phase, tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] observe();
      return {c_s4, d_s4, c_n4, d_n4, c_n3, d_n3, c_s3, d_s3};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_acc[k] = 0;
         m_cnt[k] = 0;
      end
   endtask

   task automatic clear_tally();
      out_idx = 0;
      for (int k = 0; k < 4; k++) begin
         ones[k]     = 0;
         dones[k]    = 0;
         done_pos[k] = -1;
      end
   endtask

   task automatic model_step(input int k, input logic en, input logic clr, input int s,
                             output logic [1:0] cd);
      int t;
      int cap;
      cd = 2'b00;
      if (clr) begin
         m_acc[k] = 0;
         m_cnt[k] = 0;
      end else if (en) begin
         t = m_acc[k] + s;
         if (m_mode[k] == 0) begin
            if (t >= m_n[k]) begin
               cd[1]    = 1'b1;
               m_acc[k] = t - m_n[k];
            end else begin
               m_acc[k] = t;
            end
         end else begin
            cap = (1 << m_accw[k]) - 1;
            if (t > 0) begin
               cd[1]    = 1'b1;
               m_acc[k] = (t - 1 > cap) ? cap : t - 1;
            end else begin
               m_acc[k] = 0;
            end
         end
         if (m_cnt[k] == (1 << m_bw[k]) - 1) begin
            m_acc[k] = 0;
            m_cnt[k] = 0;
            cd[0]    = 1'b1;
         end else begin
            m_cnt[k] = m_cnt[k] + 1;
         end
      end
   endtask

   task automatic step(input logic en, input logic clr, input logic [3:0] v_s4,
                       input logic [3:0] v_n4, input logic [3:0] v_n3, input logic [2:0] v_s3);
      logic [7:0] e;
      logic [7:0] obs;
      logic [1:0] cd;
      iEn  = en;
      iClr = clr;
      a_s4 = v_s4;
      a_n4 = v_n4;
      a_n3 = v_n3;
      a_s3 = v_s3;
      model_step(0, en, clr, $countones(v_s4), cd); e[7:6] = cd;
      model_step(1, en, clr, $countones(v_n4), cd); e[5:4] = cd;
      model_step(2, en, clr, $countones(v_n3), cd); e[3:2] = cd;
      model_step(3, en, clr, $countones(v_s3), cd); e[1:0] = cd;
      exp_q.push_back(e);
      @(posedge iClk);
      #1;
      obs = observe();
      check_eq("outputs", 32'(obs), 32'(exp_q.pop_front()));
      out_idx++;
      for (int k = 0; k < 4; k++) begin
         ones[k]  += int'(obs[7 - 2 * k]);
         if (obs[6 - 2 * k]) begin
            dones[k]++;
            done_pos[k] = out_idx;
         end
      end
   endtask

   initial begin
      iRst = 1'b1;
      iClr = 1'b0;
      iEn  = 1'b0;
      a_s4 = '0;
      a_n4 = '0;
      a_n3 = '0;
      a_s3 = '0;
      model_reset();
      clear_tally();
      repeat (2) @(posedge iClk);
      #1;
      phase = "reset";
      check_eq("outputs_zero", 32'(observe()), 32'd0);
      iRst = 1'b0;

      phase = "full_ones";
      clear_tally();
      repeat (8) step(1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 3'h0);
      check_eq("s4_ones", 32'(ones[0]), 32'd8);
      step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 3'h0);

      phase = "backlog_sat";
      step(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 3'h0);
      clear_tally();
      step(1'b1, 1'b0, 4'h0, 4'b0011, 4'hF, 3'h0);
      repeat (3) step(1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 3'h0);
      repeat (14) step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 3'h0);
      check_eq("n4_backlog_ones", 32'(ones[1]), 32'd2);
      check_eq("n3_saturated_ones", 32'(ones[2]), 32'd11);

      phase = "quarter";
      step(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 3'h0);
      clear_tally();
      for (int i = 0; i < 256; i++) begin
         step(1'b1, 1'b0, 4'b0001, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)));
      end
      check_eq("s4_ones", 32'(ones[0]), 32'd64);
      check_eq("s4_done_count", 32'(dones[0]), 32'd1);
      check_eq("s4_done_pos", 32'(done_pos[0]), 32'd256);

      phase = "frame";
      step(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 3'h0);
      clear_tally();
      for (int i = 0; i < 40; i++) begin
         step((i % 2) == 0, 1'b0, 4'h0, 4'h0, 4'h0, 3'b001);
      end
      check_eq("s3_done_count", 32'(dones[3]), 32'd1);
      check_eq("s3_done_pos", 32'(done_pos[3]), 32'd31);

      phase = "reset_mid";
      step(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 3'h0);
      step(1'b1, 1'b0, 4'b0011, 4'h0, 4'hF, 3'h0);
      #2;
      iRst = 1'b1;
      #1;
      check_eq("async_zero", 32'(observe()), 32'd0);
      @(posedge iClk);
      #1;
      check_eq("held_zero", 32'(observe()), 32'd0);
      #2;
      iRst = 1'b0;
      model_reset();
      step(1'b1, 1'b0, 4'b0011, 4'h0, 4'h0, 3'h0);

      phase = "clr_terminal";
      step(1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 3'h0);
      clear_tally();
      repeat (15) step(1'b1, 1'b0, 4'($urandom_range(0, 15)), 4'h0, 4'h0, 3'($urandom_range(0, 7)));
      step(1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 3'b111);
      repeat (16) step(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 3'($urandom_range(0, 7)));
      check_eq("s3_done_count", 32'(dones[3]), 32'd1);
      check_eq("s3_done_pos", 32'(done_pos[3]), 32'd32);

      phase = "random";
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
